// File: rtl/d_mem_arb_pkg.sv
// Shared types and helpers for the d_mem arbiter and its round-robin picker.
package d_mem_arb_pkg;

    // Upper bound on requesters; index-carrying registers are sized for this.
    localparam int unsigned MAX_REQ = 4;
    localparam int unsigned IDX_W   = 2;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic        wr;
        logic        lock;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  byte_en;
    } mem_req_t;

    // (base + off) mod n, returned as a requester index.
    function automatic logic [IDX_W-1:0] wrap_add(logic [IDX_W-1:0] base, int unsigned off,
                                                  int unsigned n);
        return IDX_W'((32'(base) + off) % n);
    endfunction

    // Expand byte enables into a 32-bit lane mask.
    function automatic logic [31:0] lane_mask(logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/d_mem_arb_rr_picker.sv
// Combinational round-robin picker: first valid requester at or after the pointer,
// wrapping modulo NUM_REQ. Produces a one-hot grant, its index and an any-grant flag.
module rr_picker
    import d_mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [IDX_W-1:0] w_cand;

    // Scan candidates in priority order starting at the pointer; keep the first hit.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_cand = wrap_add(i_ptr, k, NUM_REQ);
            if (!o_any && (((i_valid >> w_cand) & NUM_REQ'(1)) != '0)) begin
                o_any   = 1'b1;
                o_idx   = w_cand;
                o_grant = NUM_REQ'(1) << w_cand;
            end
        end
    end

endmodule

// File: rtl/d_mem_arb.sv
// Arbiter sharing one d_mem between NUM_REQ requesters (0 = LSU, others DMA/debug).
// Round-robin grant with an optional atomic lock, word-index translation, range
// protection and a registered single-cycle response.
module d_mem_arb
    import d_mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned MEM_SIZE_WORDS = 256,
    parameter int unsigned LOCK_TIMEOUT   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    output logic [NUM_REQ-1:0]   o_req_ready,
    input  logic [NUM_REQ-1:0]   i_req_wr,
    input  logic [NUM_REQ-1:0]   i_req_lock,
    input  logic [NUM_REQ*32-1:0] i_req_addr,
    input  logic [NUM_REQ*32-1:0] i_req_wdata,
    input  logic [NUM_REQ*4-1:0] i_req_byte_en,
    output logic [NUM_REQ-1:0]   o_rsp_valid,
    output logic [31:0]          o_rsp_rdata,
    output logic                 o_rsp_err,
    output logic                 o_lock_timeout,
    output logic [31:0]          o_mem_addr,
    output logic                 o_mem_wr_en,
    output logic [31:0]          o_mem_wr_data,
    output logic [3:0]           o_mem_byte_en,
    input  logic [31:0]          i_mem_rd_data
);

    localparam int unsigned CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    // State registers
    arb_state_t       r_state;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] r_owner;
    logic [CNT_W-1:0] r_lock_cnt;

    // Response registers
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [31:0]        r_rsp_rdata;
    logic               r_rsp_err;

    // Next-state
    arb_state_t       w_state_nxt;
    logic [IDX_W-1:0] w_rr_ptr_nxt;
    logic [IDX_W-1:0] w_owner_nxt;
    logic [CNT_W-1:0] w_lock_cnt_nxt;
    logic             w_timeout;
    logic [31:0]      w_rsp_rdata_nxt;

    // Request unpacking; entries beyond NUM_REQ are tied off so any 2-bit index is safe.
    mem_req_t          w_req [MAX_REQ];
    logic [MAX_REQ-1:0] w_valid;

    for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_req
        if (gi < NUM_REQ) begin : g_live
            assign w_req[gi] = '{
                wr:      i_req_wr[gi],
                lock:    i_req_lock[gi],
                addr:    i_req_addr[gi*32 +: 32],
                wdata:   i_req_wdata[gi*32 +: 32],
                byte_en: i_req_byte_en[gi*4 +: 4]
            };
        end else begin : g_tie
            assign w_req[gi] = '0;
        end
    end

    assign w_valid = MAX_REQ'(i_req_valid);

    // Round-robin candidate, used only while arbitrating
    logic [NUM_REQ-1:0] w_rr_grant;
    logic [IDX_W-1:0]   w_rr_idx;
    logic               w_rr_any;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_picker (
        .i_valid (i_req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_rr_grant),
        .o_idx   (w_rr_idx),
        .o_any   (w_rr_any)
    );

    // Grant selection: owner-only while locked, round-robin otherwise, nothing in reset.
    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_idx;
    logic               w_accept;

    always_comb begin
        w_grant  = '0;
        w_idx    = '0;
        w_accept = 1'b0;
        if (!i_rst) begin
            if (r_state == LOCKED) begin
                if (w_valid[r_owner]) begin
                    w_grant  = NUM_REQ'(1) << r_owner;
                    w_idx    = r_owner;
                    w_accept = 1'b1;
                end
            end else begin
                w_grant  = w_rr_grant;
                w_idx    = w_rr_idx;
                w_accept = w_rr_any;
            end
        end
    end

    mem_req_t w_sel;
    logic     w_in_range;
    logic     w_unused_addr_lsb;

    assign w_sel             = w_req[w_idx];
    assign w_in_range        = ({2'b00, w_sel.addr[31:2]} < 32'(MEM_SIZE_WORDS));
    // Byte offset within the word is irrelevant to a word memory.
    assign w_unused_addr_lsb = ^w_sel.addr[1:0];

    // Memory port follows the granted requester; idle port writes nothing.
    always_comb begin
        o_mem_addr    = '0;
        o_mem_wr_en   = 1'b0;
        o_mem_wr_data = '0;
        o_mem_byte_en = '0;
        if (w_accept) begin
            o_mem_addr    = {2'b00, w_sel.addr[31:2]};
            o_mem_wr_en   = w_sel.wr && w_in_range;
            o_mem_wr_data = w_sel.wdata;
            o_mem_byte_en = w_sel.byte_en;
        end
    end

    // FSM next-state: lock acquire/hold/release, idle timeout, round-robin pointer update.
    always_comb begin
        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_owner_nxt    = r_owner;
        w_lock_cnt_nxt = r_lock_cnt;
        w_timeout      = 1'b0;
        unique case (r_state)
            ARB: begin
                if (w_accept) begin
                    w_rr_ptr_nxt = wrap_add(w_idx, 1, NUM_REQ);
                    if (w_sel.lock) begin
                        w_state_nxt    = LOCKED;
                        w_owner_nxt    = w_idx;
                        w_lock_cnt_nxt = '0;
                    end
                end
            end
            LOCKED: begin
                if (w_accept) begin
                    w_lock_cnt_nxt = '0;
                    if (!w_sel.lock) begin
                        w_state_nxt  = ARB;
                        w_rr_ptr_nxt = wrap_add(r_owner, 1, NUM_REQ);
                    end
                end else if (r_lock_cnt == CNT_LAST) begin
                    // Owner went quiet too long: force release so others are not starved.
                    w_state_nxt    = ARB;
                    w_rr_ptr_nxt   = wrap_add(r_owner, 1, NUM_REQ);
                    w_lock_cnt_nxt = '0;
                    w_timeout      = 1'b1;
                end else begin
                    w_lock_cnt_nxt = r_lock_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ARB;
            end
        endcase
    end

    // FSM state register with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ARB;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_owner    <= w_owner_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end

    // Read data returned only for in-range reads, masked to the requested lanes.
    always_comb begin
        w_rsp_rdata_nxt = '0;
        if (w_accept && !w_sel.wr && w_in_range) begin
            w_rsp_rdata_nxt = i_mem_rd_data & lane_mask(w_sel.byte_en);
        end
    end

    // Response register: one-cycle pulse to last cycle's acceptor; reset drops it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_grant;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_accept && !w_in_range;
        end
    end

    assign o_req_ready    = w_grant;
    assign o_rsp_valid    = r_rsp_valid;
    assign o_rsp_rdata    = r_rsp_rdata;
    assign o_rsp_err      = r_rsp_err;
    assign o_lock_timeout = w_timeout && !i_rst;

endmodule

// File: tb/tb_d_mem_arb.sv
// Self-checking bench for d_mem_arb: directed scenarios followed by random traffic,
// all checked against a behavioural arbiter/memory model.
module tb_d_mem_arb;

    localparam int NUM   = 2;
    localparam int WORDS = 256;
    localparam int TO    = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM-1:0]    req_valid, req_ready, req_wr, req_lock;
    logic [NUM*32-1:0] req_addr, req_wdata;
    logic [NUM*4-1:0]  req_byte_en;
    logic [NUM-1:0]    rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err, lock_timeout;
    logic [31:0]       mem_addr, mem_wr_data, mem_rd_data;
    logic              mem_wr_en;
    logic [3:0]        mem_byte_en;

    always #5 clk = ~clk;

    d_mem_arb #(
        .NUM_REQ        (NUM),
        .MEM_SIZE_WORDS (WORDS),
        .LOCK_TIMEOUT   (TO)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_wr       (req_wr),
        .i_req_lock     (req_lock),
        .i_req_addr     (req_addr),
        .i_req_wdata    (req_wdata),
        .i_req_byte_en  (req_byte_en),
        .o_rsp_valid    (rsp_valid),
        .o_rsp_rdata    (rsp_rdata),
        .o_rsp_err      (rsp_err),
        .o_lock_timeout (lock_timeout),
        .o_mem_addr     (mem_addr),
        .o_mem_wr_en    (mem_wr_en),
        .o_mem_wr_data  (mem_wr_data),
        .o_mem_byte_en  (mem_byte_en),
        .i_mem_rd_data  (mem_rd_data)
    );

    function automatic logic [31:0] init_word(int i);
        return (i == 4) ? 32'h11223344 : ((32'(i) * 32'h01010101) ^ 32'hA5A50000);
    endfunction

    // Attached d_mem: combinational read, byte-lane write on posedge, reloaded on reset.
    logic [31:0] mem [WORDS];
    assign mem_rd_data = mem[mem_addr[7:0]];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= init_word(i);
        end else if (mem_wr_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_byte_en[b]) mem[mem_addr[7:0]][8*b +: 8] <= mem_wr_data[8*b +: 8];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit             m_locked, m_prev_rst;
    int             m_owner, m_ptr, m_idle;
    logic [31:0]    ref_mem [WORDS];
    logic [NUM-1:0] e_rsp_valid;
    logic [31:0]    e_rsp_rdata;
    logic           e_rsp_err;

    // Observations from the most recent step
    logic [NUM-1:0] seen_ready, seen_rsp;
    logic [31:0]    seen_rdata;
    logic           seen_err, seen_to, seen_wr_en;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked    = 1'b0;
        m_owner     = 0;
        m_ptr       = 0;
        m_idle      = 0;
        e_rsp_valid = '0;
        e_rsp_rdata = '0;
        e_rsp_err   = 1'b0;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
    endtask

    task automatic set_req(input int r, input logic v, input logic wr, input logic lk,
                           input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        req_valid[r]         = v;
        req_wr[r]            = wr;
        req_lock[r]          = lk;
        req_addr[r*32 +: 32] = a;
        req_wdata[r*32 +: 32] = d;
        req_byte_en[r*4 +: 4] = be;
    endtask

    task automatic idle_all();
        for (int r = 0; r < NUM; r++) set_req(r, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    // One clock cycle: predict, compare, clock, advance the model. Called just after negedge.
    task automatic step();
        int             g;
        logic [NUM-1:0] exp_ready;
        logic           exp_to, wr, lk, inr;
        logic [31:0]    a, d;
        logic [3:0]     be;
        #1;
        g = -1;
        if (!rst) begin
            if (m_locked) begin
                if (req_valid[m_owner]) g = m_owner;
            end else begin
                for (int k = 0; k < NUM; k++)
                    if (g < 0 && req_valid[(m_ptr + k) % NUM]) g = (m_ptr + k) % NUM;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        exp_to = !rst && m_locked && !req_valid[m_owner] && (m_idle == TO - 1);

        seen_ready = req_ready;
        seen_rsp   = rsp_valid;
        seen_rdata = rsp_rdata;
        seen_err   = rsp_err;
        seen_to    = lock_timeout;
        seen_wr_en = mem_wr_en;

        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("lock_timeout", 32'(lock_timeout), 32'(exp_to));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp_valid));
        if (e_rsp_valid != '0 || m_prev_rst) begin
            chk("rsp_rdata", rsp_rdata, e_rsp_rdata);
            chk("rsp_err", 32'(rsp_err), 32'(e_rsp_err));
        end

        wr = 1'b0; lk = 1'b0; a = '0; d = '0; be = '0; inr = 1'b0;
        if (g >= 0) begin
            wr  = req_wr[g];
            lk  = req_lock[g];
            a   = req_addr[g*32 +: 32];
            d   = req_wdata[g*32 +: 32];
            be  = req_byte_en[g*4 +: 4];
            inr = (a[31:2] < WORDS);
            chk("mem_addr", mem_addr, {2'b00, a[31:2]});
            chk("mem_wr_en", 32'(mem_wr_en), 32'(wr && inr));
            chk("mem_byte_en", 32'(mem_byte_en), 32'(be));
            chk("mem_wr_data", mem_wr_data, d);
        end else begin
            chk("idle_wr_en", 32'(mem_wr_en), 32'h0);
            chk("idle_byte_en", 32'(mem_byte_en), 32'h0);
        end

        @(posedge clk);
        if (rst) begin
            model_reset();
            m_prev_rst = 1'b1;
        end else begin
            m_prev_rst  = 1'b0;
            e_rsp_valid = '0;
            e_rsp_rdata = '0;
            e_rsp_err   = 1'b0;
            if (g >= 0) begin
                e_rsp_valid[g] = 1'b1;
                e_rsp_err      = !inr;
                if (inr) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[b]) begin
                            if (wr) ref_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
                            else    e_rsp_rdata[8*b +: 8] = ref_mem[a[9:2]][8*b +: 8];
                        end
                    end
                end
                if (!m_locked) begin
                    m_ptr = (g + 1) % NUM;
                    if (lk) begin
                        m_locked = 1'b1;
                        m_owner  = g;
                        m_idle   = 0;
                    end
                end else if (lk) begin
                    m_idle = 0;
                end else begin
                    m_locked = 1'b0;
                    m_ptr    = (m_owner + 1) % NUM;
                end
            end else if (m_locked) begin
                if (m_idle == TO - 1) begin
                    m_locked = 1'b0;
                    m_ptr    = (m_owner + 1) % NUM;
                    m_idle   = 0;
                end else begin
                    m_idle++;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [NUM-1:0] exp_g [4];
        int             pulses, diffs, pick;
        logic [31:0]    ra;

        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        m_prev_rst = 1'b1;
        rst = 1'b1;
        idle_all();
        set_req(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
        set_req(1, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 4'hF);
        @(posedge clk);
        @(negedge clk);
        model_reset();

        // Reset held with every requester valid: no grant, no response.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_no_ready", 32'(seen_ready), 32'h0);
            chk("reset_no_rsp", 32'(seen_rsp), 32'h0);
        end

        // Contention straight out of reset: 0,1,0,1 with responses one cycle later.
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("contend_grant", 32'(seen_ready), 32'(exp_g[i]));
            if (i > 0) chk("contend_rsp", 32'(seen_rsp), 32'(exp_g[i-1]));
        end
        idle_all();
        step();
        chk("contend_rsp_last", 32'(seen_rsp), 32'(exp_g[3]));

        // Partial-lane write then immediate full read of the same word.
        set_req(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'hAABBCCDD, 4'b0101);
        step();
        set_req(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'hF);
        step();
        idle_all();
        step();
        chk("byte_merge", seen_rdata, 32'h11BB33DD);

        // Zero byte enables: write leaves memory alone, read returns zero.
        set_req(0, 1'b1, 1'b1, 1'b0, 32'h14, 32'hFFFFFFFF, 4'h0);
        step();
        set_req(0, 1'b1, 1'b0, 1'b0, 32'h14, 32'h0, 4'h0);
        step();
        set_req(0, 1'b1, 1'b0, 1'b0, 32'h14, 32'h0, 4'hF);
        step();
        chk("be0_rdata", seen_rdata, 32'h0);
        idle_all();
        step();
        chk("be0_nowrite", seen_rdata, init_word(5));

        // First address past the end errors and never writes; the last word is writable.
        set_req(0, 1'b1, 1'b1, 1'b0, 32'h400, 32'hDEADBEEF, 4'hF);
        step();
        chk("oor_wr_en", 32'(seen_wr_en), 32'h0);
        set_req(0, 1'b1, 1'b1, 1'b0, 32'h3FC, 32'h0BADF00D, 4'hF);
        step();
        chk("oor_err", 32'(seen_err), 32'h1);
        chk("oor_rdata", seen_rdata, 32'h0);
        chk("last_word_wr_en", 32'(seen_wr_en), 32'h1);
        idle_all();
        step();
        chk("last_word_err", 32'(seen_err), 32'h0);
        diffs = 0;
        for (int i = 0; i < WORDS; i++) if (mem[i] !== ref_mem[i]) diffs++;
        chk("mem_image_oor", 32'(diffs), 32'h0);

        // Lock held by req1 starves req0 until req1 releases with lock=0.
        set_req(0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 4'hF);
        set_req(1, 1'b1, 1'b0, 1'b1, 32'h24, 32'h0, 4'hF);
        step();
        chk("lock_take", 32'(seen_ready), 32'h2);
        set_req(1, 1'b0, 1'b0, 1'b0, 32'h24, 32'h0, 4'hF);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("lock_starve", 32'(seen_ready), 32'h0);
        end
        set_req(1, 1'b1, 1'b1, 1'b0, 32'h24, 32'h12345678, 4'hF);
        step();
        chk("lock_release", 32'(seen_ready), 32'h2);
        set_req(1, 1'b0, 1'b0, 1'b0, 32'h24, 32'h0, 4'hF);
        step();
        chk("after_release", 32'(seen_ready), 32'h1);

        // Lock timeout: req1 locks then goes idle.
        set_req(0, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 4'hF);
        set_req(1, 1'b1, 1'b0, 1'b1, 32'h28, 32'h0, 4'hF);
        step();
        chk("to_take", 32'(seen_ready), 32'h2);
        set_req(0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 4'hF);
        set_req(1, 1'b0, 1'b0, 1'b0, 32'h28, 32'h0, 4'hF);
        pulses = 0;
        for (int i = 0; i < TO; i++) begin
            step();
            if (seen_to === 1'b1) pulses++;
            chk("to_blocked", 32'(seen_ready), 32'h0);
        end
        chk("to_pulse_last", 32'(seen_to), 32'h1);
        chk("to_pulse_count", 32'(pulses), 32'h1);
        step();
        chk("to_regrant", 32'(seen_ready), 32'h1);
        chk("to_no_repulse", 32'(seen_to), 32'h0);

        // Reset in the middle of a lock returns to arbitration.
        set_req(0, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 4'hF);
        set_req(1, 1'b1, 1'b0, 1'b1, 32'h2C, 32'h0, 4'hF);
        step();
        set_req(0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 4'hF);
        set_req(1, 1'b0, 1'b0, 1'b0, 32'h2C, 32'h0, 4'hF);
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        chk("rst_lock_ready", 32'(seen_ready), 32'h0);
        rst = 1'b0;
        step();
        chk("rst_lock_rsp", 32'(seen_rsp), 32'h0);
        chk("rst_lock_grant", 32'(seen_ready), 32'h1);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int r = 0; r < NUM; r++) begin
                pick = $urandom_range(0, 9);
                if (pick == 0)      ra = 32'h400 + ($urandom_range(0, 15) << 2);
                else if (pick == 1) ra = 32'h3FC;
                else                ra = ($urandom_range(0, WORDS - 1) << 2) | $urandom_range(0, 3);
                set_req(r, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 7) == 0), ra, $urandom, 4'($urandom_range(0, 15)));
            end
            step();
        end
        rst = 1'b0;
        idle_all();
        step();
        diffs = 0;
        for (int i = 0; i < WORDS; i++) if (mem[i] !== ref_mem[i]) diffs++;
        chk("mem_image_final", 32'(diffs), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
